// File: rtl/dbus_arbiter.sv
// Two-master round-robin arbiter onto a single shared data bus, one transaction in flight.
// Optional response timeout is enabled by defining DBUS_ARB_TIMEOUT_EN.
module dbus_arbiter #(
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_sel_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_sel_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_rdata_o,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_sel_o,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic [31:0] s_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  state_t      state;
  logic        last_grant;   // 1 = m1 was served last
  logic        grant;        // master owning the current transaction
  logic        pick;
  logic        done;
  logic        done_err;
  logic [31:0] done_rdata;

`ifdef DBUS_ARB_TIMEOUT_EN
  // Counter reaches all-ones on the same edge the timeout completes the transaction.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = ~(TIMEOUT_W'(1));
  logic [TIMEOUT_W-1:0] tmo_cnt;
`endif

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    pick       = m1_req_i && (!m0_req_i || !last_grant);
    done       = s_ack_i;
    done_err   = s_err_i;
    done_rdata = s_rdata_i;
`ifdef DBUS_ARB_TIMEOUT_EN
    if (!s_ack_i && tmo_cnt == TMO_LAST) begin
      done       = 1'b1;
      done_err   = 1'b1;
      done_rdata = '0;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      s_req_o    <= 1'b0;
      s_we_o     <= 1'b0;
      s_addr_o   <= '0;
      s_wdata_o  <= '0;
      s_sel_o    <= '0;
      m0_ack_o   <= 1'b0;
      m0_err_o   <= 1'b0;
      m0_rdata_o <= '0;
      m1_ack_o   <= 1'b0;
      m1_err_o   <= 1'b0;
      m1_rdata_o <= '0;
`ifdef DBUS_ARB_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (m0_req_i || m1_req_i) begin
            grant     <= pick;
            s_req_o   <= 1'b1;
            s_we_o    <= pick ? m1_we_i    : m0_we_i;
            s_addr_o  <= pick ? m1_addr_i  : m0_addr_i;
            s_wdata_o <= pick ? m1_wdata_i : m0_wdata_i;
            s_sel_o   <= pick ? m1_sel_i   : m0_sel_i;
            state     <= REQ;
`ifdef DBUS_ARB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end
        REQ: begin
`ifdef DBUS_ARB_TIMEOUT_EN
          if (!s_ack_i) tmo_cnt <= tmo_cnt + 1'b1;
`endif
          if (done) begin
            s_req_o    <= 1'b0;
            last_grant <= grant;
            state      <= ACK;
            if (grant) begin
              m1_ack_o   <= 1'b1;
              m1_err_o   <= done_err;
              m1_rdata_o <= done_rdata;
            end else begin
              m0_ack_o   <= 1'b1;
              m0_err_o   <= done_err;
              m0_rdata_o <= done_rdata;
            end
          end
        end
        ACK: begin
          m0_ack_o   <= 1'b0;
          m0_err_o   <= 1'b0;
          m0_rdata_o <= '0;
          m1_ack_o   <= 1'b0;
          m1_err_o   <= 1'b0;
          m1_rdata_o <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed self-checking bench for dbus_arbiter; define DBUS_ARB_TIMEOUT_EN to also
// exercise the response timeout with a 4-bit counter.
module tb_dbus_arbiter;

`ifdef DBUS_ARB_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 8;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [3:0]  s_sel_o;
  logic        s_ack_i, s_err_i;
  logic [31:0] s_rdata_i;

  int tests  = 0;
  int failed = 0;
  int n;

  dbus_arbiter #(.TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_sel_i(m0_sel_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_sel_i(m1_sel_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rdata_i(s_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_sreq"}, 32'(s_req_o), 32'd0);
    check({tag, "_acks"}, {28'd0, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 32'd0);
    check({tag, "_rd0"}, m0_rdata_o, 32'd0);
    check({tag, "_rd1"}, m1_rdata_o, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    m0_req_i = 0; m0_we_i = 0; m0_addr_i = 0; m0_wdata_i = 0; m0_sel_i = 0;
    m1_req_i = 0; m1_we_i = 0; m1_addr_i = 0; m1_wdata_i = 0; m1_sel_i = 0;
    s_ack_i = 0; s_err_i = 0; s_rdata_i = 0;
    cycle();
    cycle();
    rst = 1'b0;
    check_quiet("reset");
    check("reset_saddr", s_addr_o, 32'd0);

    // Single m0 read, ack in the first REQ cycle.
    m0_req_i = 1; m0_addr_i = 32'h8000_0010; m0_sel_i = 4'hF;
    cycle();
    check("rd_sreq", 32'(s_req_o), 32'd1);
    check("rd_saddr", s_addr_o, 32'h8000_0010);
    check("rd_swe", 32'(s_we_o), 32'd0);
    s_ack_i = 1; s_rdata_i = 32'hDEAD_BEEF;
    cycle();
    s_ack_i = 0; s_rdata_i = 32'h5555_AAAA; m0_req_i = 0;
    check("rd_ack", 32'(m0_ack_o), 32'd1);
    check("rd_rdata", m0_rdata_o, 32'hDEAD_BEEF);
    check("rd_err", 32'(m0_err_o), 32'd0);
    check("rd_m1ack", {m1_ack_o, m1_rdata_o[30:0]}, 32'd0);
    check("rd_sreq_drop", 32'(s_req_o), 32'd0);
    cycle();
    check_quiet("rd_after");

    // Reset again so the contention starts from the reset last_grant value.
    rst = 1; cycle(); rst = 0;
    m0_addr_i = 32'h0000_1000; m1_addr_i = 32'h0000_2000;
    m0_req_i = 1; m1_req_i = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check($sformatf("rr%0d_saddr", i), s_addr_o, (i % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
      s_ack_i = 1; s_rdata_i = 32'h100 + 32'(i);
      cycle();
      s_ack_i = 0;
      check($sformatf("rr%0d_acks", i), {30'd0, m1_ack_o, m0_ack_o}, (i % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("rr%0d_rdata", i), (i % 2 == 0) ? m0_rdata_o : m1_rdata_o, 32'h100 + 32'(i));
      cycle();
    end
    m0_req_i = 0; m1_req_i = 0;
    cycle();

    // m1 write with the ack held off for five REQ cycles; m1 inputs change meanwhile.
    m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h0040_0000; m1_wdata_i = 32'h1234_5678; m1_sel_i = 4'hF;
    cycle();
    m1_addr_i = 32'hFFFF_0000; m1_wdata_i = 32'h0; m1_we_i = 0; m1_sel_i = 4'h1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("wr%0d_saddr", i), s_addr_o, 32'h0040_0000);
      check($sformatf("wr%0d_swdata", i), s_wdata_o, 32'h1234_5678);
      check($sformatf("wr%0d_ctl", i), {26'd0, s_req_o, s_we_o, s_sel_o}, 32'h3F);
      check($sformatf("wr%0d_noack", i), {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
      if (i == 2) s_err_i = 1;
      if (i == 3) s_err_i = 0;
      if (i == 5) s_ack_i = 1;
      cycle();
    end
    s_ack_i = 0; m1_req_i = 0;
    check("wr_ack", 32'(m1_ack_o), 32'd1);
    check("wr_err", 32'(m1_err_o), 32'd0);
    check("wr_m0", {m0_ack_o, m0_rdata_o[30:0]}, 32'd0);
    n = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n += int'(m1_ack_o);
    end
    check("wr_pulses", 32'(n), 32'd1);

    // Error response, then stray bus acks while idle.
    m0_req_i = 1; m0_addr_i = 32'h0000_0044;
    cycle();
    s_ack_i = 1; s_err_i = 1; s_rdata_i = 32'hCAFE_0001;
    cycle();
    s_ack_i = 0; s_err_i = 0; m0_req_i = 0;
    check("err_ack", {30'd0, m0_ack_o, m0_err_o}, 32'd3);
    cycle();
    s_ack_i = 1; s_err_i = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_quiet($sformatf("idle_ack%0d", i));
    end
    s_ack_i = 0; s_err_i = 0;

    // m0 completes (last_grant = m0), then m1 is reset in its third REQ cycle.
    m0_req_i = 1;
    cycle();
    s_ack_i = 1;
    cycle();
    s_ack_i = 0; m0_req_i = 0;
    cycle();
    m1_req_i = 1; m1_addr_i = 32'h0000_3000;
    cycle();
    cycle();
    cycle();
    check("rst_mid_sreq", 32'(s_req_o), 32'd1);
    rst = 1; s_ack_i = 1;
    cycle();
    rst = 0; s_ack_i = 0;
    check_quiet("rst_mid");
    check("rst_mid_saddr", s_addr_o, 32'd0);
    m0_req_i = 1; m0_addr_i = 32'h0000_4000;
    cycle();
    check("rst_win_saddr", s_addr_o, 32'h0000_4000);
    check("rst_win_noack", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
    s_ack_i = 1;
    cycle();
    s_ack_i = 0; m0_req_i = 0; m1_req_i = 0;
    check("rst_win_ack", {30'd0, m1_ack_o, m0_ack_o}, 32'd1);
    cycle();

`ifdef DBUS_ARB_TIMEOUT_EN
    // No bus ack: 15 REQ cycles, then an error completion with zero data.
    m0_req_i = 1; s_rdata_i = 32'h7777_7777;
    cycle();
    n = 0;
    while (s_req_o && n < 40) begin
      n++;
      cycle();
    end
    m0_req_i = 0;
    check("tmo_cycles", 32'(n), 32'd15);
    check("tmo_ack", {30'd0, m0_ack_o, m0_err_o}, 32'd3);
    check("tmo_rdata", m0_rdata_o, 32'd0);
    cycle();
    check_quiet("tmo_after");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
